// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared encodings for the memory-access stage
// (load_op bit positions, FSM states, ms_to_ws_bus field offsets).
package mem_stage_pkg;

  // load_op is one-hot {w, hu, h, bu, b}
  localparam int LD_B  = 0;
  localparam int LD_BU = 1;
  localparam int LD_H  = 2;
  localparam int LD_HU = 3;
  localparam int LD_W  = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_HELD = 2'd2
  } ms_state_e;

  localparam int BUS_PC_LSB   = 0;
  localparam int BUS_RES_LSB  = 32;
  localparam int BUS_DEST_LSB = 64;
  localparam int BUS_GRWE_BIT = 69;
  localparam int BUS_EX_BIT   = 70;
  localparam int BUS_SIDE_LSB = 71;

endpackage

// File: rtl/mem_stage_if.sv
// mem_stage_if: EX-side, data-response, WB-side and decode-forwarding signals of mem_stage.
interface mem_stage_if #(
  parameter int SIDE_W = 160
);
  logic                 es_to_ms_valid;
  logic                 ms_allowin;
  logic [31:0]          es_pc;
  logic [31:0]          es_result;
  logic [4:0]           es_dest;
  logic                 es_gr_we;
  logic [4:0]           es_load_op;
  logic                 es_mem_req;
  logic                 es_ex;
  logic [SIDE_W-1:0]    es_side;
  logic                 data_sram_data_ok;
  logic [31:0]          data_sram_rdata;
  logic                 ws_allowin;
  logic                 ws_flush_pipe;
  logic                 ms_to_ws_valid;
  logic [SIDE_W+70:0]   ms_to_ws_bus;
  logic                 ms_fwd_we;
  logic [4:0]           ms_fwd_dest;
  logic [31:0]          ms_fwd_data;
  logic                 ms_fwd_block;

  modport master (
    output es_to_ms_valid, es_pc, es_result, es_dest, es_gr_we, es_load_op,
           es_mem_req, es_ex, es_side, data_sram_data_ok, data_sram_rdata,
           ws_allowin, ws_flush_pipe,
    input  ms_allowin, ms_to_ws_valid, ms_to_ws_bus, ms_fwd_we, ms_fwd_dest,
           ms_fwd_data, ms_fwd_block
  );

  modport slave (
    input  es_to_ms_valid, es_pc, es_result, es_dest, es_gr_we, es_load_op,
           es_mem_req, es_ex, es_side, data_sram_data_ok, data_sram_rdata,
           ws_allowin, ws_flush_pipe,
    output ms_allowin, ms_to_ws_valid, ms_to_ws_bus, ms_fwd_we, ms_fwd_dest,
           ms_fwd_data, ms_fwd_block
  );
endinterface

// File: rtl/mem_stage_load_align.sv
// mem_stage_load_align: picks the byte/halfword at addr_lo out of the response word and extends it.
module mem_stage_load_align
  import mem_stage_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [4:0]  load_op_i,
  output logic [31:0] data_o
);
  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Lane select followed by sign/zero extension according to the one-hot load_op
  always_comb begin
    case (addr_lo_i)
      2'd0:    byte_s = rdata_i[7:0];
      2'd1:    byte_s = rdata_i[15:8];
      2'd2:    byte_s = rdata_i[23:16];
      2'd3:    byte_s = rdata_i[31:24];
      default: byte_s = rdata_i[7:0];
    endcase
    if (addr_lo_i[1]) begin
      half_s = rdata_i[31:16];
    end else begin
      half_s = rdata_i[15:0];
    end
    if (load_op_i[LD_B]) begin
      data_o = {{24{byte_s[7]}}, byte_s};
    end else if (load_op_i[LD_BU]) begin
      data_o = {24'd0, byte_s};
    end else if (load_op_i[LD_H]) begin
      data_o = {{16{half_s[15]}}, half_s};
    end else if (load_op_i[LD_HU]) begin
      data_o = {16'd0, half_s};
    end else if (load_op_i[LD_W]) begin
      data_o = rdata_i;
    end else begin
      data_o = rdata_i;
    end
  end
endmodule

// File: rtl/mem_stage.sv
// mem_stage: pipeline memory-access stage between EX and WB, with load-response wait and discard.
// Optional MS_LOAD_FWD_EN: forward extracted load data to decode from the data_ok cycle on.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int SIDE_W = 160,
  parameter int DISC_W = 2
) (
  input logic        clk,
  input logic        reset,
  mem_stage_if.slave ms
);
  logic              ms_valid_q;
  ms_state_e         state_q;
  logic [DISC_W-1:0] disc_cnt_q;
  logic [DISC_W-1:0] disc_cnt_d;
  logic [31:0]       pc_q;
  logic [31:0]       result_q;
  logic [31:0]       hold_q;
  logic [4:0]        dest_q;
  logic [4:0]        load_op_q;
  logic              gr_we_q;
  logic              mem_req_q;
  logic              ex_q;
  logic [SIDE_W-1:0] side_q;

  logic              disc_zero_s;
  logic              resp_ok_s;
  logic              ready_go_s;
  logic              allowin_s;
  logic              is_load_s;
  logic [31:0]       align_s;
  logic [31:0]       final_result_s;
  logic [SIDE_W+70:0] bus_s;

  mem_stage_load_align u_load_align (
    .rdata_i   (ms.data_sram_rdata),
    .addr_lo_i (result_q[1:0]),
    .load_op_i (load_op_q),
    .data_o    (align_s)
  );

  // Handshake, result selection and discard-counter next state
  always_comb begin
    disc_zero_s = (disc_cnt_q == {DISC_W{1'b0}});
    resp_ok_s   = (state_q == S_WAIT) && ms.data_sram_data_ok && disc_zero_s;
    is_load_s   = (load_op_q != 5'd0);
    case (state_q)
      S_IDLE:  ready_go_s = 1'b1;
      S_WAIT:  ready_go_s = resp_ok_s;
      S_HELD:  ready_go_s = 1'b1;
      default: ready_go_s = 1'b0;
    endcase
    allowin_s = !reset && !ms.ws_flush_pipe && disc_zero_s
              && (!ms_valid_q || (ready_go_s && ms.ws_allowin));
    if (is_load_s && !ex_q && (state_q == S_HELD)) begin
      final_result_s = hold_q;
    end else if (is_load_s && !ex_q && mem_req_q) begin
      final_result_s = align_s;
    end else begin
      final_result_s = result_q;
    end
    // A flushed request still owes a response; count it so it is never consumed.
    if (!disc_zero_s && ms.data_sram_data_ok) begin
      disc_cnt_d = disc_cnt_q - DISC_W'(1);
    end else if (ms.ws_flush_pipe && (state_q == S_WAIT) && !ms.data_sram_data_ok) begin
      disc_cnt_d = disc_cnt_q + DISC_W'(1);
    end else begin
      disc_cnt_d = disc_cnt_q;
    end
  end

  // Stage registers and the IDLE/WAIT/HELD state machine
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ms_valid_q <= 1'b0;
      state_q    <= S_IDLE;
      disc_cnt_q <= {DISC_W{1'b0}};
      pc_q       <= 32'd0;
      result_q   <= 32'd0;
      hold_q     <= 32'd0;
      dest_q     <= 5'd0;
      load_op_q  <= 5'd0;
      gr_we_q    <= 1'b0;
      mem_req_q  <= 1'b0;
      ex_q       <= 1'b0;
      side_q     <= {SIDE_W{1'b0}};
    end else begin
      disc_cnt_q <= disc_cnt_d;
      if (ms.ws_flush_pipe) begin
        ms_valid_q <= 1'b0;
        state_q    <= S_IDLE;
      end else if (allowin_s) begin
        ms_valid_q <= ms.es_to_ms_valid;
        if (ms.es_to_ms_valid) begin
          pc_q      <= ms.es_pc;
          result_q  <= ms.es_result;
          dest_q    <= ms.es_dest;
          gr_we_q   <= ms.es_gr_we;
          load_op_q <= ms.es_load_op;
          mem_req_q <= ms.es_mem_req;
          ex_q      <= ms.es_ex;
          side_q    <= ms.es_side;
          state_q   <= (ms.es_mem_req && !ms.es_ex) ? S_WAIT : S_IDLE;
        end else begin
          state_q <= S_IDLE;
        end
      end else begin
        case (state_q)
          S_WAIT: begin
            if (resp_ok_s) begin
              hold_q  <= align_s;
              state_q <= S_HELD;
            end
          end
          default: state_q <= state_q;
        endcase
      end
    end
  end

  // Pack the WB bus from its field offsets
  always_comb begin
    bus_s = {(SIDE_W+71){1'b0}};
    bus_s[BUS_PC_LSB +: 32]       = pc_q;
    bus_s[BUS_RES_LSB +: 32]      = final_result_s;
    bus_s[BUS_DEST_LSB +: 5]      = dest_q;
    bus_s[BUS_GRWE_BIT]           = gr_we_q;
    bus_s[BUS_EX_BIT]             = ex_q;
    bus_s[BUS_SIDE_LSB +: SIDE_W] = side_q;
  end

  assign ms.ms_allowin     = allowin_s;
  assign ms.ms_to_ws_valid = ms_valid_q && ready_go_s && !ms.ws_flush_pipe;
  assign ms.ms_to_ws_bus   = bus_s;
  assign ms.ms_fwd_we      = ms_valid_q && gr_we_q && !ex_q;
  assign ms.ms_fwd_dest    = dest_q;
`ifdef MS_LOAD_FWD_EN
  assign ms.ms_fwd_data    = final_result_s;
  assign ms.ms_fwd_block   = ms_valid_q && is_load_s && (state_q != S_HELD) && !resp_ok_s;
`else
  assign ms.ms_fwd_data    = result_q;
  assign ms.ms_fwd_block   = ms_valid_q && is_load_s;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed test-plan scenarios followed by constrained-random traffic,
// every cycle compared against a transaction-level model of the stage.
module tb_mem_stage;
  localparam int SIDE_W = 160;
  localparam int BW     = SIDE_W + 71;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_stage_if #(.SIDE_W(SIDE_W)) bus_if ();
  mem_stage #(.SIDE_W(SIDE_W), .DISC_W(2)) dut (.clk(clk), .reset(reset), .ms(bus_if));

  int checks = 0;
  int errors = 0;

  // Reference model: the instruction held in MS and the number of responses still to drop
  bit                m_v, m_we, m_req, m_ex, m_have;
  logic [31:0]       m_pc, m_res, m_held;
  logic [4:0]        m_dest, m_op;
  logic [SIDE_W-1:0] m_side;
  int                m_disc;
  bit                e_allow, e_valid, e_block, e_resp, e_wait;
  logic [31:0]       e_final;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Load value from the word with shifts, masks and two's-complement arithmetic
  function automatic logic [31:0] ref_load(input logic [4:0] op, input logic [31:0] rd,
                                           input logic [1:0] a);
    logic [31:0] v;
    if (op == 5'b00001 || op == 5'b00010) begin
      v = (rd >> (32'd8 * a)) & 32'h0000_00FF;
      if (op == 5'b00001 && v >= 32'h80) v = v - 32'h100;
    end else if (op == 5'b00100 || op == 5'b01000) begin
      v = (rd >> (32'd16 * a[1])) & 32'h0000_FFFF;
      if (op == 5'b00100 && v >= 32'h8000) v = v - 32'h1_0000;
    end else begin
      v = rd;
    end
    return v;
  endfunction

  task automatic model_reset();
    m_v = 0; m_we = 0; m_req = 0; m_ex = 0; m_have = 0;
    m_pc = 32'd0; m_res = 32'd0; m_held = 32'd0; m_dest = 5'd0; m_op = 5'd0;
    m_side = '0; m_disc = 0;
  endtask

  task automatic model_eval();
    bit need, ready, load;
    need    = m_v && m_req && !m_ex;
    e_wait  = need && !m_have;
    e_resp  = e_wait && (bus_if.data_sram_data_ok === 1'b1) && (m_disc == 0);
    ready   = !e_wait || e_resp;
    load    = (m_op != 5'd0);
    e_allow = !bus_if.ws_flush_pipe && (m_disc == 0) && (!m_v || (ready && bus_if.ws_allowin));
    e_valid = m_v && ready && !bus_if.ws_flush_pipe;
    if (need && load) e_final = m_have ? m_held : ref_load(m_op, bus_if.data_sram_rdata, m_res[1:0]);
    else e_final = m_res;
`ifdef MS_LOAD_FWD_EN
    e_block = m_v && load && !(need && ready);
`else
    e_block = m_v && load;
`endif
  endtask

  task automatic check_now();
    #2;
    model_eval();
    chk1("allowin", bus_if.ms_allowin, e_allow);
    chk1("to_ws_valid", bus_if.ms_to_ws_valid, e_valid);
    if (e_valid) chkw("ws_bus", bus_if.ms_to_ws_bus, {m_side, m_ex, m_we, m_dest, e_final, m_pc});
    chk1("fwd_we", bus_if.ms_fwd_we, m_v && m_we && !m_ex);
    chk1("fwd_block", bus_if.ms_fwd_block, e_block);
    if (m_v) begin
      chk32("fwd_dest", {27'd0, bus_if.ms_fwd_dest}, {27'd0, m_dest});
`ifdef MS_LOAD_FWD_EN
      if (!e_block) chk32("fwd_data", bus_if.ms_fwd_data, e_final);
`else
      chk32("fwd_data", bus_if.ms_fwd_data, m_res);
`endif
    end
  endtask

  task automatic clock();
    int nd;
    model_eval();
    nd = m_disc;
    if (bus_if.data_sram_data_ok && m_disc > 0) nd = nd - 1;
    if (bus_if.ws_flush_pipe && e_wait && !bus_if.data_sram_data_ok) nd = nd + 1;
    if (bus_if.ws_flush_pipe) begin
      m_v = 0; m_have = 0;
    end else if (e_allow) begin
      m_v = bus_if.es_to_ms_valid;
      if (bus_if.es_to_ms_valid) begin
        m_pc = bus_if.es_pc; m_res = bus_if.es_result; m_dest = bus_if.es_dest;
        m_we = bus_if.es_gr_we; m_op = bus_if.es_load_op; m_req = bus_if.es_mem_req;
        m_ex = bus_if.es_ex; m_side = bus_if.es_side; m_have = 0;
      end
    end else if (e_resp) begin
      m_have = 1;
      m_held = ref_load(m_op, bus_if.data_sram_rdata, m_res[1:0]);
    end
    m_disc = nd;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus_if.es_to_ms_valid = 1'b0; bus_if.es_mem_req = 1'b0;
    bus_if.data_sram_data_ok = 1'b0; bus_if.ws_flush_pipe = 1'b0; bus_if.ws_allowin = 1'b1;
  endtask

  task automatic set_insn(input logic [31:0] pc, input logic [31:0] res, input logic [4:0] op,
                          input logic we, input logic [4:0] dest, input logic req, input logic ex);
    bus_if.es_pc = pc; bus_if.es_result = res; bus_if.es_load_op = op; bus_if.es_gr_we = we;
    bus_if.es_dest = dest; bus_if.es_mem_req = req; bus_if.es_ex = ex;
    bus_if.es_side = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
  endtask

  task automatic check_zero(input string tag);
    chk1({tag, "_allowin"}, bus_if.ms_allowin, 1'b0);
    chk1({tag, "_valid"}, bus_if.ms_to_ws_valid, 1'b0);
    chkw({tag, "_bus"}, bus_if.ms_to_ws_bus, {BW{1'b0}});
    chk1({tag, "_fwd_we"}, bus_if.ms_fwd_we, 1'b0);
    chk32({tag, "_fwd_dest"}, {27'd0, bus_if.ms_fwd_dest}, 32'd0);
    chk32({tag, "_fwd_data"}, bus_if.ms_fwd_data, 32'd0);
    chk1({tag, "_fwd_block"}, bus_if.ms_fwd_block, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    bus_if.data_sram_rdata = 32'd0;
    set_insn(32'd0, 32'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    model_reset();
    #1;
    check_zero("reset");
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    check_now(); chk1("post_reset_allowin", bus_if.ms_allowin, 1'b1); clock();

    // ld.b at addr_lo 3, response two cycles after accept
    set_insn(32'h1000, 32'h2003, 5'b00001, 1'b1, 5'd3, 1'b1, 1'b0);
    bus_if.es_to_ms_valid = 1'b1;
    check_now(); chk1("ldb_accept", bus_if.ms_allowin, 1'b1); clock();
    idle_inputs();
    check_now(); chk1("ldb_wait_block", bus_if.ms_fwd_block, 1'b1); clock();
    bus_if.data_sram_data_ok = 1'b1; bus_if.data_sram_rdata = 32'h80FF_1234;
    check_now();
    chk1("ldb_valid", bus_if.ms_to_ws_valid, 1'b1);
    chk32("ldb_result", bus_if.ms_to_ws_bus[63:32], 32'hFFFF_FF80);
    clock();
    idle_inputs();
    check_now(); chk1("ldb_single_pulse", bus_if.ms_to_ws_valid, 1'b0); clock();

    // ld.hu at addr_lo 2 with WB stalled around the response
    set_insn(32'h1004, 32'h2002, 5'b01000, 1'b1, 5'd4, 1'b1, 1'b0);
    bus_if.es_to_ms_valid = 1'b1;
    check_now(); clock();
    idle_inputs(); bus_if.ws_allowin = 1'b0;
    check_now(); clock();
    bus_if.data_sram_data_ok = 1'b1; bus_if.data_sram_rdata = 32'h8001_0000;
    check_now(); chk32("ldhu_result", bus_if.ms_to_ws_bus[63:32], 32'h0000_8001); clock();
    bus_if.data_sram_data_ok = 1'b0; bus_if.data_sram_rdata = 32'hDEAD_BEEF;
    check_now();
    chk1("ldhu_held_valid", bus_if.ms_to_ws_valid, 1'b1);
    chk32("ldhu_held_result", bus_if.ms_to_ws_bus[63:32], 32'h0000_8001);
    clock();
    bus_if.ws_allowin = 1'b1;
    check_now(); chk32("ldhu_release", bus_if.ms_to_ws_bus[63:32], 32'h0000_8001); clock();
    check_now(); chk1("ldhu_gone", bus_if.ms_to_ws_valid, 1'b0); clock();

    // add: one-cycle latency, forwarded without block
    set_insn(32'h1008, 32'h0000_1234, 5'd0, 1'b1, 5'd7, 1'b0, 1'b0);
    bus_if.es_to_ms_valid = 1'b1;
    check_now(); clock();
    idle_inputs();
    check_now();
    chk1("add_valid", bus_if.ms_to_ws_valid, 1'b1);
    chk32("add_fwd_data", bus_if.ms_fwd_data, 32'h0000_1234);
    chk1("add_fwd_block", bus_if.ms_fwd_block, 1'b0);
    clock();

    // Flush while waiting: the late response is dropped, the next load gets the next one
    set_insn(32'h100C, 32'h3000, 5'b10000, 1'b1, 5'd8, 1'b1, 1'b0);
    bus_if.es_to_ms_valid = 1'b1;
    check_now(); clock();
    idle_inputs(); bus_if.ws_flush_pipe = 1'b1;
    check_now(); chk1("flush_valid", bus_if.ms_to_ws_valid, 1'b0); clock();
    idle_inputs();
    check_now(); chk1("disc_allowin_t1", bus_if.ms_allowin, 1'b0); clock();
    check_now(); chk1("disc_allowin_t2", bus_if.ms_allowin, 1'b0); clock();
    bus_if.data_sram_data_ok = 1'b1; bus_if.data_sram_rdata = 32'h1111_1111;
    check_now();
    chk1("disc_allowin_t3", bus_if.ms_allowin, 1'b0);
    chk1("disc_dropped", bus_if.ms_to_ws_valid, 1'b0);
    clock();
    idle_inputs();
    set_insn(32'h1010, 32'h4000, 5'b10000, 1'b1, 5'd9, 1'b1, 1'b0);
    bus_if.es_to_ms_valid = 1'b1;
    check_now(); chk1("disc_done_allowin", bus_if.ms_allowin, 1'b1); clock();
    idle_inputs(); bus_if.data_sram_data_ok = 1'b1; bus_if.data_sram_rdata = 32'h2222_3333;
    check_now();
    chk1("next_load_valid", bus_if.ms_to_ws_valid, 1'b1);
    chk32("next_load_result", bus_if.ms_to_ws_bus[63:32], 32'h2222_3333);
    clock();

    // Flush in the same cycle as the response: nothing left to discard
    set_insn(32'h1014, 32'h5001, 5'b00010, 1'b1, 5'd10, 1'b1, 1'b0);
    idle_inputs(); bus_if.es_to_ms_valid = 1'b1;
    check_now(); clock();
    idle_inputs(); bus_if.ws_flush_pipe = 1'b1; bus_if.data_sram_data_ok = 1'b1;
    bus_if.data_sram_rdata = $urandom();
    check_now(); chk1("flush_ok_valid", bus_if.ms_to_ws_valid, 1'b0); clock();
    idle_inputs();
    check_now(); chk1("flush_ok_allowin", bus_if.ms_allowin, 1'b1); clock();

    // Asynchronous reset while a load waits
    set_insn(32'h1018, 32'h6002, 5'b00100, 1'b1, 5'd11, 1'b1, 1'b0);
    bus_if.es_to_ms_valid = 1'b1;
    check_now(); clock();
    idle_inputs();
    check_now();
    #1; reset = 1'b1; #1;
    check_zero("async_reset");
    model_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    check_now(); chk1("reset_release_allowin", bus_if.ms_allowin, 1'b1); clock();

    // Constrained-random traffic
    for (int i = 0; i < 600; i++) begin
      int kind;
      int outstanding;
      model_eval();
      outstanding = m_disc + (e_wait ? 1 : 0);
      bus_if.ws_flush_pipe     = ($urandom_range(0, 15) == 0);
      bus_if.ws_allowin        = ($urandom_range(0, 3) != 0);
      bus_if.data_sram_data_ok = (outstanding > 0) && ($urandom_range(0, 2) == 0);
      bus_if.data_sram_rdata   = $urandom();
      kind = int'($urandom_range(0, 3));
      case (kind)
        0: set_insn($urandom(), $urandom(), 5'd0, 1'($urandom_range(0, 1)),
                    5'($urandom_range(0, 31)), 1'b0, 1'b0);
        1: set_insn($urandom(), $urandom(), 5'd1 << $urandom_range(0, 4), 1'b1,
                    5'($urandom_range(0, 31)), 1'b1, 1'b0);
        2: set_insn($urandom(), $urandom(), 5'd0, 1'b0, 5'($urandom_range(0, 31)), 1'b1, 1'b0);
        default: set_insn($urandom(), $urandom(), 5'd1 << $urandom_range(0, 4),
                          1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 1'b0, 1'b1);
      endcase
      bus_if.es_to_ms_valid = 1'($urandom_range(0, 1));
      model_eval();
      if (!e_allow) bus_if.es_mem_req = 1'b0;
      check_now();
      clock();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
